// File: rtl/cache_arbiter.sv
// Two-port to one-port arbiter in front of shared memory. The icache
// (line fills) and dcache (fills and writebacks) compete for a single
// memory channel; one transaction is in flight at a time.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no transaction; sample requests, grant, latch address/data
// SERVE_I | icache fill in flight; mem_read held from latched regs
// SERVE_D | dcache fill or writeback in flight; mem_read/mem_write held
// RESP    | one-cycle completion pulse to the granted side
module cache_arbiter #(
  parameter int s_line = 256,
  parameter int s_addr = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [s_addr-1:0] i_address,
  output logic [s_line-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [s_addr-1:0] d_address,
  input  logic [s_line-1:0] d_wdata,
  output logic [s_line-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [s_addr-1:0] mem_address,
  output logic [s_line-1:0] mem_wdata,
  input  logic [s_line-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state;
  logic   last_grant;  // 0 = icache served last, 1 = dcache served last
  logic   grant_d;     // side owning the current transaction
  logic   d_req;
  logic   pick_d;

  assign d_req = d_read | d_write;

  // dcache wins when it is alone, or on a tie when icache was served last
  assign pick_d = d_req & (~i_read | ~last_grant);

  // Arbitration FSM; memory-side signals are driven only from latched regs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b0;
      grant_d     <= 1'b0;
      i_rdata     <= '0;
      i_resp      <= 1'b0;
      d_rdata     <= '0;
      d_resp      <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (i_read || d_req) begin
            if (pick_d) begin
              grant_d     <= 1'b1;
              mem_address <= d_address;
              mem_wdata   <= d_wdata;
              // a combined read+write request is a writeback
              mem_write   <= d_write;
              mem_read    <= ~d_write;
              state       <= SERVE_D;
            end else begin
              grant_d     <= 1'b0;
              mem_address <= i_address;
              mem_write   <= 1'b0;
              mem_read    <= 1'b1;
              state       <= SERVE_I;
            end
          end
        end
        SERVE_I: begin
          if (mem_resp) begin
            i_rdata  <= mem_rdata;
            i_resp   <= 1'b1;
            mem_read <= 1'b0;
            state    <= RESP;
          end
        end
        SERVE_D: begin
          if (mem_resp) begin
            // writebacks leave the dcache fill data untouched
            if (!mem_write) begin
              d_rdata <= mem_rdata;
            end
            d_resp    <= 1'b1;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: begin
          last_grant <= grant_d;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 SHALL have parameter: s_line, 256, cache line width in bits.
REQ-002 SHALL have parameter: s_addr, 32, physical address width in bits.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port: i_read  input  1  icache line-fill request, held until i_resp.
REQ-006 SHALL have port: i_address  input  s_addr  icache line address.
REQ-007 SHALL have port: i_rdata  output  s_line  fill data to icache, registered.
REQ-008 SHALL have port: i_resp  output  1  icache completion pulse.
REQ-009 SHALL have port: d_read  input  1  dcache line-fill request, held until d_resp.
REQ-010 SHALL have port: d_write  input  1  dcache writeback request, held until d_resp.
REQ-011 SHALL have port: d_address  input  s_addr  dcache line address.
REQ-012 SHALL have port: d_wdata  input  s_line  dcache writeback data.
REQ-013 SHALL have port: d_rdata  output  s_line  fill data to dcache, registered.
REQ-014 SHALL have port: d_resp  output  1  dcache completion pulse.
REQ-015 SHALL have port: mem_read  output  1  read request to shared memory.
REQ-016 SHALL have port: mem_write  output  1  write request to shared memory.
REQ-017 SHALL have port: mem_address  output  s_addr  latched request address.
REQ-018 SHALL have port: mem_wdata  output  s_line  latched writeback data.
REQ-019 SHALL have port: mem_rdata  input  s_line  memory read data, valid with mem_resp.
REQ-020 SHALL have port: mem_resp  input  1  memory completion, one cycle.

Function
REQ-021 SHALL implement FSM states IDLE, SERVE_I, SERVE_D, RESP.
REQ-022 IDLE: no request -> stay; request(s) present -> grant per REQ-023, latch address (plus d_wdata and op for dcache) into internal regs, go to SERVE_I/SERVE_D next edge.
REQ-023 Simultaneous icache and dcache requests in IDLE SHALL be granted round-robin: requester not granted last wins; last_grant after reset = icache (dcache wins first tie).
REQ-024 SERVE_x: mem_read or mem_write SHALL be asserted every cycle, driven only from latched regs; changes on requester inputs during SERVE SHALL be ignored.
REQ-025 dcache with d_read and d_write both high SHALL be treated as write.
REQ-026 SERVE_x with mem_resp=1: capture mem_rdata into the granted requester's rdata reg (reads only), deassert mem_read/mem_write from next cycle, go to RESP.
REQ-027 RESP: assert i_resp or d_resp (granted side only) for exactly one cycle, update last_grant, return to IDLE; requests are not sampled in RESP.
REQ-028 Latency: grant edge to mem request 1 cycle; mem_resp to requester resp 1 cycle; minimum request-to-resp latency = memory latency + 2 cycles.
REQ-029 mem_resp while in IDLE or RESP SHALL be ignored with no state change.
REQ-030 i_rdata/d_rdata SHALL hold last captured value until next read completion for that side; writes SHALL NOT modify d_rdata.
REQ-031 mem_read and mem_write SHALL never be high in the same cycle; i_resp and d_resp SHALL never be high in the same cycle.
REQ-032 Requester SHALL deassert its request in the cycle after its resp; an arbiter in IDLE seeing a still-held request SHALL start a new transaction.

Reset
REQ-033 On rst=1, immediately and asynchronously: state=IDLE, last_grant=icache, all outputs and latched regs = 0.
REQ-034 rst asserted mid-SERVE SHALL abort the transaction with no resp issued; a later stale mem_resp SHALL be ignored per REQ-029.

Verification
REQ-035 icache-only: i_read=1, i_address=0x0000_0060, memory returns 0xAA..AA after 3 cycles -> mem_read high 3 cycles with mem_address=0x60, i_rdata=0xAA..AA, i_resp one cycle, 5 cycles total.
REQ-036 Tie after reset: i_read and d_read both high in the same cycle -> dcache served first, icache served immediately after, each resp exactly one pulse.
REQ-037 Writeback: d_write=1, d_address=0x8000_0100, d_wdata=0x1234..  -> mem_write=1 with those values, mem_read=0, d_resp pulse, d_rdata unchanged.
REQ-038 Input change mid-serve: i_address changes 0x40->0x80 during SERVE_I -> mem_address stays 0x40 until resp.
REQ-039 Reset mid-transaction: rst pulsed during SERVE_D, then mem_resp arrives -> all outputs 0, no d_resp, state IDLE.
REQ-040 Fairness: both sides requesting continuously for 6 transactions -> grants strictly alternate D,I,D,I,D,I.
